// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single write port of a small register file
// between an ALU writeback requester (slot 0) and a memory-load requester
// (slot 1). Each requester owns a one-deep holding slot. A round-robin arbiter
// (age-aware for same-register conflicts) drains one slot per cycle into a
// registered write stage that drives the register file write port.
module rf_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_hazard,
    output logic              write_reg_en,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    // stage p0: holding slots (valid, destination register, data)
    logic              vld0_p0;
    logic              vld1_p0;
    logic [ADDR_W-1:0] reg0_p0;
    logic [ADDR_W-1:0] reg1_p0;
    logic [DATA_W-1:0] data0_p0;
    logic [DATA_W-1:0] data1_p0;

    // Arbitration state: age=1 means slot 1 holds the older entry;
    // last_grant=1 means slot 1 was the most recent winner.
    logic age;
    logic age_next;
    logic last_grant;

    logic grant0;
    logic grant1;
    logic accept0;
    logic accept1;

    // True when either read port addresses the given register.
    function automatic logic read_hit(input logic [ADDR_W-1:0] target,
                                      input logic [ADDR_W-1:0] addr_a,
                                      input logic [ADDR_W-1:0] addr_b);
        return (target == addr_a) || (target == addr_b);
    endfunction

    // Pick at most one full slot; same-register conflicts keep write order.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (vld0_p0 && vld1_p0) begin
            if (reg0_p0 == reg1_p0) begin
                grant1 = age;
                grant0 = !age;
            end else begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end
        end else begin
            grant0 = vld0_p0;
            grant1 = vld1_p0;
        end
    end

    // A slot accepts when empty or when it is being drained this cycle;
    // readies are forced low while reset is held.
    always_comb begin
        req0_ready = rst && (!vld0_p0 || grant0);
        req1_ready = rst && (!vld1_p0 || grant1);
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
    end

    // Track which slot is older after this edge; on a simultaneous fill the
    // load slot (1) is treated as older.
    always_comb begin
        age_next = age;
        if (accept0 && accept1) begin
            age_next = 1'b1;
        end else if (accept0 && vld1_p0 && !grant1) begin
            age_next = 1'b1;
        end else if (accept1 && vld0_p0 && !grant0) begin
            age_next = 1'b0;
        end
    end

    // Slot occupancy: fill on accept, empty on grant without refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld0_p0 <= 1'b0;
            vld1_p0 <= 1'b0;
        end else begin
            vld0_p0 <= accept0 || (vld0_p0 && !grant0);
            vld1_p0 <= accept1 || (vld1_p0 && !grant1);
        end
    end

    // Slot payload capture; contents are only meaningful while the slot is full.
    always_ff @(posedge clk) begin
        if (accept0) begin
            reg0_p0  <= req0_reg;
            data0_p0 <= req0_data;
        end
        if (accept1) begin
            reg1_p0  <= req1_reg;
            data1_p0 <= req1_data;
        end
    end

    // Round-robin pointer and age bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            age        <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
            age <= age_next;
        end
    end

    // stage p1: registered write port into the register file
    // Write stage: enable follows any grant; address/data hold when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_reg_en <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
        end else begin
            write_reg_en <= grant0 || grant1;
            if (grant0) begin
                write_reg  <= reg0_p0;
                write_data <= data0_p0;
            end else if (grant1) begin
                write_reg  <= reg1_p0;
                write_data <= data1_p0;
            end
        end
    end

    // Read-after-write hazard against both slots and the write stage.
    always_comb begin
        rd_hazard = (vld0_p0 && read_hit(reg0_p0, rd_addr1, rd_addr2)) ||
                    (vld1_p0 && read_hit(reg1_p0, rd_addr1, rd_addr2)) ||
                    (write_reg_en && read_hit(write_reg, rd_addr1, rd_addr2));
        busy      = vld0_p0 || vld1_p0 || write_reg_en;
    end

endmodule
